// File: rtl/sme_job_scheduler_pkg.sv
// Shared constants and types for the SME job scheduler.
// SME limits: 32 string bytes, 8 pattern bytes, 5-bit match index.
package sme_pkg;
   localparam int STR_MAX = 32;
   localparam int PAT_MAX = 8;
   localparam int IDX_W   = 5;
   localparam int STR_CW  = $clog2(STR_MAX + 1);
   localparam int PAT_CW  = $clog2(PAT_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_STREAM,
      ST_WAIT,
      ST_RESP
   } sme_sched_state_t;
endpackage

// File: rtl/sme_job_scheduler_if.sv
// Requester, SME and response signals of the SME job scheduler.
// master = scheduler side, slave = requesters plus SME.
interface sme_job_scheduler_if #(
   parameter int NREQ = 4
);
   import sme_pkg::*;

   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   gnt;
   logic [NREQ*8-1:0] req_chardata;
   logic [NREQ-1:0]   req_isstring;
   logic [NREQ-1:0]   req_ispattern;
   logic [7:0]        sme_chardata;
   logic              sme_isstring;
   logic              sme_ispattern;
   logic              sme_valid;
   logic              sme_match;
   logic [IDX_W-1:0]  sme_match_index;
   logic [NREQ-1:0]   rsp_valid;
   logic              rsp_match;
   logic [IDX_W-1:0]  rsp_match_index;
   logic              rsp_stale;
   logic [NREQ-1:0]   str_resident;
   logic              err_timeout;

   modport master (
      input  req, req_chardata, req_isstring, req_ispattern,
      input  sme_valid, sme_match, sme_match_index,
      output gnt, sme_chardata, sme_isstring, sme_ispattern,
      output rsp_valid, rsp_match, rsp_match_index, rsp_stale,
      output str_resident, err_timeout
   );

   modport slave (
      output req, req_chardata, req_isstring, req_ispattern,
      output sme_valid, sme_match, sme_match_index,
      input  gnt, sme_chardata, sme_isstring, sme_ispattern,
      input  rsp_valid, rsp_match, rsp_match_index, rsp_stale,
      input  str_resident, err_timeout
   );
endinterface

// File: rtl/sme_job_scheduler_arb.sv
// Combinational round-robin pick: first request at or after ptr_i.
module sme_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o
);
   logic hit;

   always_comb begin
      gnt_o = '0;
      hit   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!hit && req_i[i] && PW'(i) >= ptr_i) begin
            gnt_o[i] = 1'b1;
            hit      = 1'b1;
         end
      end
      // wrap-around pass for requests below the pointer
      for (int i = 0; i < NREQ; i++) begin
         if (!hit && req_i[i]) begin
            gnt_o[i] = 1'b1;
            hit      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/sme_job_scheduler.sv
// Shares one SME string-match engine between NREQ requesters:
// round-robin grant, byte forwarding, result routing, residency tracking.
module sme_job_scheduler
   import sme_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int WAIT_TMO = 4096,
   parameter int GNT_TMO  = 16
) (
   input logic clk,
   input logic reset,
   sme_job_scheduler_if.master bus
);
   localparam int PW      = $clog2(NREQ);
   localparam int TMO_MAX = (WAIT_TMO > GNT_TMO) ? WAIT_TMO : GNT_TMO;
   localparam int TW      = $clog2(TMO_MAX + 1);

   sme_sched_state_t  state_q;
   logic [NREQ-1:0]   gnt_q, arb_gnt;
   logic [PW-1:0]     owner_q, rr_q, arb_idx, nxt_ptr;
   logic [PW-1:0]     res_owner_q;
   logic              res_valid_q;
   logic [TW-1:0]     tmo_q;
   logic [STR_CW-1:0] str_cnt_q;
   logic [PAT_CW-1:0] pat_cnt_q;
   logic              pat_prev_q, pat_run_q, stale_q;
   logic [7:0]        sme_data_q;
   logic              sme_str_q, sme_pat_q;
   logic [NREQ-1:0]   rsp_valid_q, str_res_q, str_res_d;
   logic              rsp_match_q, rsp_stale_q, err_tmo_q;
   logic [IDX_W-1:0]  rsp_idx_q;
   logic [7:0]        g_dat;
   logic              g_str, g_pat;

   sme_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
      .req_i (bus.req),
      .ptr_i (rr_q),
      .gnt_o (arb_gnt)
   );

   always_comb begin
      arb_idx = '0;
      for (int i = 0; i < NREQ; i++)
         if (arb_gnt[i]) arb_idx = PW'(i);
   end

   always_comb begin
      g_dat = '0;
      g_str = 1'b0;
      g_pat = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_q[i]) begin
            g_dat = bus.req_chardata[8*i +: 8];
            g_str = bus.req_isstring[i];
            g_pat = bus.req_ispattern[i];
         end
      end
   end

   assign nxt_ptr   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
   assign str_res_d = res_valid_q ? ({{(NREQ-1){1'b0}}, 1'b1} << res_owner_q) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         gnt_q       <= '0;
         owner_q     <= '0;
         rr_q        <= '0;
         res_owner_q <= '0;
         res_valid_q <= 1'b0;
         tmo_q       <= '0;
         str_cnt_q   <= '0;
         pat_cnt_q   <= '0;
         pat_prev_q  <= 1'b0;
         pat_run_q   <= 1'b0;
         stale_q     <= 1'b0;
         sme_data_q  <= '0;
         sme_str_q   <= 1'b0;
         sme_pat_q   <= 1'b0;
         rsp_valid_q <= '0;
         rsp_match_q <= 1'b0;
         rsp_idx_q   <= '0;
         rsp_stale_q <= 1'b0;
         err_tmo_q   <= 1'b0;
         str_res_q   <= '0;
      end else begin
         sme_data_q  <= '0;
         sme_str_q   <= 1'b0;
         sme_pat_q   <= 1'b0;
         rsp_valid_q <= '0;
         rsp_match_q <= 1'b0;
         rsp_idx_q   <= '0;
         rsp_stale_q <= 1'b0;
         err_tmo_q   <= 1'b0;
         str_res_q   <= str_res_d;
         unique case (state_q)
            ST_IDLE: begin
               if (|bus.req) begin
                  gnt_q      <= arb_gnt;
                  owner_q    <= arb_idx;
                  tmo_q      <= '0;
                  str_cnt_q  <= '0;
                  pat_cnt_q  <= '0;
                  pat_prev_q <= 1'b0;
                  pat_run_q  <= 1'b0;
                  stale_q    <= 1'b0;
                  state_q    <= ST_GRANT;
               end
            end
            ST_GRANT, ST_STREAM: begin
               if (state_q == ST_GRANT && !(g_str || g_pat)) begin
                  if (tmo_q == TW'(GNT_TMO - 1)) begin
                     gnt_q   <= '0;
                     rr_q    <= nxt_ptr;
                     state_q <= ST_IDLE;
                  end else begin
                     tmo_q <= tmo_q + 1'b1;
                  end
               end else if (pat_prev_q && !g_pat) begin
                  tmo_q   <= '0;
                  state_q <= ST_WAIT;
               end else begin
                  state_q    <= ST_STREAM;
                  pat_prev_q <= g_pat;
                  if (g_str) begin
                     res_valid_q <= 1'b1;
                     res_owner_q <= owner_q;
                     if (str_cnt_q < STR_CW'(STR_MAX)) begin
                        sme_str_q  <= 1'b1;
                        sme_data_q <= g_pat ? 8'h00 : g_dat;
                        str_cnt_q  <= str_cnt_q + 1'b1;
                     end
                  end else if (g_pat) begin
                     if (!pat_run_q)
                        stale_q <= !(res_valid_q && res_owner_q == owner_q);
                     pat_run_q <= 1'b1;
                     if (pat_cnt_q < PAT_CW'(PAT_MAX)) begin
                        sme_pat_q  <= 1'b1;
                        sme_data_q <= g_dat;
                        pat_cnt_q  <= pat_cnt_q + 1'b1;
                     end
                  end
               end
            end
            ST_WAIT: begin
               if (bus.sme_valid) begin
                  rsp_valid_q <= gnt_q;
                  rsp_match_q <= bus.sme_match;
                  rsp_idx_q   <= bus.sme_match ? bus.sme_match_index : '0;
                  rsp_stale_q <= stale_q;
                  gnt_q       <= '0;
                  state_q     <= ST_RESP;
               end else if (tmo_q == TW'(WAIT_TMO - 1)) begin
                  // engine hung: its string contents can no longer be trusted
                  rsp_valid_q <= gnt_q;
                  rsp_stale_q <= stale_q;
                  err_tmo_q   <= 1'b1;
                  res_valid_q <= 1'b0;
                  gnt_q       <= '0;
                  state_q     <= ST_RESP;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            ST_RESP: begin
               rr_q    <= nxt_ptr;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.gnt             = gnt_q;
   assign bus.sme_chardata    = sme_data_q;
   assign bus.sme_isstring    = sme_str_q;
   assign bus.sme_ispattern   = sme_pat_q;
   assign bus.rsp_valid       = rsp_valid_q;
   assign bus.rsp_match       = rsp_match_q;
   assign bus.rsp_match_index = rsp_idx_q;
   assign bus.rsp_stale       = rsp_stale_q;
   assign bus.str_resident    = str_res_q;
   assign bus.err_timeout     = err_tmo_q;
endmodule
